// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction-fetch and data-access ports: data wins by default, but instruction fetch is forced through after MAX_STREAK data grants.
// Optional: define MEM_ARB_PERF_CNT_EN to add the conflict and instruction-wait performance counters.
module mem_port_arbiter #(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        busy_o,
  output logic [31:0] perf_conflict_cnt_o,
  output logic [31:0] perf_instr_wait_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_GNT,
    S_WAIT_RESP
  } state_t;

  typedef enum logic {
    OWN_INSTR,
    OWN_DATA
  } owner_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  state_t     state_q, state_d;
  owner_t     owner_q, owner_d;
  logic [3:0] streak_q, streak_d;

  logic req_any;
  logic win_data;
  logic sel_data;
  logic bus_req;
  logic instr_gnt;
  logic data_gnt;
  logic instr_rvalid;
  logic data_rvalid;

  assign req_any  = instr_req_i | data_req_i;
  assign win_data = data_req_i & ~(instr_req_i & (streak_q == STREAK_MAX));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_INSTR;
      streak_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    bus_req      = 1'b0;
    sel_data     = (owner_q == OWN_DATA);
    instr_gnt    = 1'b0;
    data_gnt     = 1'b0;
    instr_rvalid = 1'b0;
    data_rvalid  = 1'b0;

    case (state_q)
      S_IDLE: begin
        sel_data  = win_data;
        bus_req   = req_any;
        instr_gnt = req_any & ~win_data & bus_gnt_i;
        data_gnt  = win_data & bus_gnt_i;
        if (req_any) begin
          owner_d = win_data ? OWN_DATA : OWN_INSTR;
          state_d = bus_gnt_i ? S_WAIT_RESP : S_WAIT_GNT;
        end
      end
      // Owner is locked in here: a late data request must not steal a committed fetch.
      S_WAIT_GNT: begin
        bus_req   = 1'b1;
        instr_gnt = ~sel_data & bus_gnt_i;
        data_gnt  = sel_data & bus_gnt_i;
        if (bus_gnt_i) begin
          state_d = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        if (bus_rvalid_i) begin
          instr_rvalid = ~sel_data;
          data_rvalid  = sel_data;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    streak_d = streak_q;
    if (data_gnt) begin
      if (!instr_req_i) begin
        streak_d = 4'd0;
      end else if (streak_q != STREAK_MAX) begin
        streak_d = streak_q + 4'd1;
      end
    end else if (instr_gnt) begin
      streak_d = 4'd0;
    end
  end

  assign bus_req_o      = bus_req & rst_n_i;
  assign instr_gnt_o    = instr_gnt & rst_n_i;
  assign data_gnt_o     = data_gnt & rst_n_i;
  assign instr_rvalid_o = instr_rvalid & rst_n_i;
  assign data_rvalid_o  = data_rvalid & rst_n_i;

  assign bus_addr_o  = sel_data ? data_addr_i  : instr_addr_i;
  assign bus_we_o    = sel_data & data_we_i;
  assign bus_be_o    = sel_data ? data_be_i    : 4'hF;
  assign bus_wdata_o = sel_data ? data_wdata_i : 32'h0;

  assign instr_rdata_o = bus_rdata_i;
  assign data_rdata_o  = bus_rdata_i;
  assign busy_o        = (state_q != S_IDLE);

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt_q;
  logic [31:0] instr_wait_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      conflict_cnt_q   <= 32'd0;
      instr_wait_cnt_q <= 32'd0;
    end else begin
      if ((state_q == S_IDLE) && instr_req_i && data_req_i) begin
        conflict_cnt_q <= conflict_cnt_q + 32'd1;
      end
      if (instr_req_i && !instr_gnt_o) begin
        instr_wait_cnt_q <= instr_wait_cnt_q + 32'd1;
      end
    end
  end

  assign perf_conflict_cnt_o   = conflict_cnt_q;
  assign perf_instr_wait_cnt_o = instr_wait_cnt_q;
`else
  assign perf_conflict_cnt_o   = 32'd0;
  assign perf_instr_wait_cnt_o = 32'd0;
`endif

endmodule
